// File: rtl/ttt_pkg.sv
// Shared codes for the tic-tac-toe move sequencer: symbols, players, winners,
// sequencer states and the ASCII keys it understands.
package ttt_pkg;

   localparam logic [1:0] SYM_EMPTY = 2'b00;
   localparam logic [1:0] SYM_X     = 2'b01;
   localparam logic [1:0] SYM_O     = 2'b10;

   localparam logic [1:0] PLAYER_1  = 2'b01;
   localparam logic [1:0] PLAYER_2  = 2'b10;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_TIE   = 2'b11;

   localparam logic [1:0] RESULT_TIE = 2'b11;

   typedef enum logic [2:0] {
      S_POS,
      S_SYM,
      S_COMMIT,
      S_DRAW,
      S_DRAW_WAIT,
      S_CHECK,
      S_OVER
   } state_t;

   localparam logic [6:0] ASC_0  = 7'h30;
   localparam logic [6:0] ASC_1  = 7'h31;
   localparam logic [6:0] ASC_9  = 7'h39;
   localparam logic [6:0] ASC_X  = 7'h58;
   localparam logic [6:0] ASC_XL = 7'h78;
   localparam logic [6:0] ASC_O  = 7'h4F;
   localparam logic [6:0] ASC_OL = 7'h6F;
   localparam logic [6:0] ASC_R  = 7'h52;
   localparam logic [6:0] ASC_RL = 7'h72;
   localparam logic [6:0] ASC_U  = 7'h55;
   localparam logic [6:0] ASC_UL = 7'h75;

   // Cell n (1..9) lives at bits [2n-1:2n-2].
   function automatic logic [1:0] cell_at(input logic [17:0] cells, input logic [3:0] pos);
      logic [4:0] lo;
      lo = {pos, 1'b0} - 5'd2;
      return 2'(cells >> lo);
   endfunction

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == PLAYER_1) ? PLAYER_2 : PLAYER_1;
   endfunction

endpackage

// File: rtl/key_classify.sv
// Combinational decode of a keyboard ASCII code into the key classes the
// move sequencer reacts to.
module key_classify (
   input  logic [6:0] key_ascii,
   output logic       is_digit,
   output logic [3:0] digit,
   output logic       is_x,
   output logic       is_o,
   output logic       is_r,
   output logic       is_u
);
   import ttt_pkg::*;

   always_comb begin
      is_digit = (key_ascii >= ASC_1) && (key_ascii <= ASC_9);
      digit    = is_digit ? 4'(key_ascii - ASC_0) : 4'd0;
      is_x     = (key_ascii == ASC_X) || (key_ascii == ASC_XL);
      is_o     = (key_ascii == ASC_O) || (key_ascii == ASC_OL);
      is_r     = (key_ascii == ASC_R) || (key_ascii == ASC_RL);
      is_u     = (key_ascii == ASC_U) || (key_ascii == ASC_UL);
   end

endmodule

// File: rtl/move_sequencer.sv
// Keyboard-driven move sequencer: position/symbol entry, board write, render
// handshake with timeout, end-of-game check. Define MOVE_UNDO_EN for one-level undo.
module move_sequencer #(
   parameter int DRAW_TIMEOUT = 1024
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        key_valid,
   input  logic [6:0]  key_ascii,
   input  logic [17:0] cell_state,
   input  logic        check,
   input  logic [1:0]  result,
   input  logic        draw_done,
   output logic        wr_en,
   output logic [3:0]  wr_pos,
   output logic [1:0]  wr_sym,
   output logic        draw_start,
   output logic [1:0]  turn,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic        err
);
   import ttt_pkg::*;

   localparam int             CNT_W    = $clog2(DRAW_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_TIMEOUT - 1);

   logic       key_is_digit, key_is_x, key_is_o, key_is_r, key_is_u;
   logic [3:0] key_digit;
   logic       digit_free;

   key_classify u_key (
      .key_ascii (key_ascii),
      .is_digit  (key_is_digit),
      .digit     (key_digit),
      .is_x      (key_is_x),
      .is_o      (key_is_o),
      .is_r      (key_is_r),
      .is_u      (key_is_u)
   );

   assign digit_free = key_is_digit && (cell_at(cell_state, key_digit) == SYM_EMPTY);

   state_t           state_q, state_d;
   logic [3:0]       pos_q, pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       turn_q, turn_d;
   logic             game_over_q, game_over_d;
   logic [1:0]       winner_q, winner_d;
   logic             wr_en_q, wr_en_d;
   logic [3:0]       wr_pos_q, wr_pos_d;
   logic [1:0]       wr_sym_q, wr_sym_d;
   logic             draw_start_q, draw_start_d;
   logic             err_q, err_d;

`ifdef MOVE_UNDO_EN
   logic [3:0] last_pos_q, last_pos_d;
   logic [1:0] last_turn_q, last_turn_d;
   logic       last_vld_q, last_vld_d;
   logic       undo_q, undo_d;
`else
   logic unused_u;
   assign unused_u = key_is_u;
`endif

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      cnt_d        = cnt_q;
      turn_d       = turn_q;
      game_over_d  = game_over_q;
      winner_d     = winner_q;
      wr_en_d      = 1'b0;
      wr_pos_d     = 4'd0;
      wr_sym_d     = SYM_EMPTY;
      draw_start_d = 1'b0;
      err_d        = 1'b0;
`ifdef MOVE_UNDO_EN
      last_pos_d   = last_pos_q;
      last_turn_d  = last_turn_q;
      last_vld_d   = last_vld_q;
      undo_d       = undo_q;
`endif
      // Outputs are registered, so strobes are raised on the transition into
      // the state that owns them and line up with that state's cycle.
      case (state_q)
         S_POS: begin
            if (key_valid) begin
               if (digit_free) begin
                  pos_d   = key_digit;
                  state_d = S_SYM;
               end
`ifdef MOVE_UNDO_EN
               else if (key_is_u && last_vld_q) begin
                  wr_en_d    = 1'b1;
                  wr_pos_d   = last_pos_q;
                  wr_sym_d   = SYM_EMPTY;
                  last_vld_d = 1'b0;
                  undo_d     = 1'b1;
                  state_d    = S_COMMIT;
               end
`endif
               else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SYM: begin
            if (key_valid) begin
               if (key_is_x || key_is_o) begin
                  wr_en_d  = 1'b1;
                  wr_pos_d = pos_q;
                  wr_sym_d = key_is_x ? SYM_X : SYM_O;
                  state_d  = S_COMMIT;
`ifdef MOVE_UNDO_EN
                  last_pos_d  = pos_q;
                  last_turn_d = turn_q;
                  last_vld_d  = 1'b1;
                  undo_d      = 1'b0;
`endif
               end else if (digit_free) begin
                  pos_d = key_digit;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_COMMIT: begin
            draw_start_d = 1'b1;
            state_d      = S_DRAW;
         end
         S_DRAW: begin
            cnt_d   = '0;
            state_d = S_DRAW_WAIT;
         end
         S_DRAW_WAIT: begin
            if (draw_done) begin
               state_d = S_CHECK;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            state_d = S_POS;
`ifdef MOVE_UNDO_EN
            if (undo_q) begin
               // Hand the move back to whoever made the undone move.
               turn_d = last_turn_q;
               undo_d = 1'b0;
            end else
`endif
            if (!check) begin
               turn_d = other_player(turn_q);
            end else begin
               game_over_d = 1'b1;
               winner_d    = (result == RESULT_TIE) ? WIN_TIE : other_player(turn_q);
               state_d     = S_OVER;
            end
         end
         S_OVER: begin
            if (key_valid && key_is_r) begin
               state_d     = S_POS;
               pos_d       = 4'd0;
               cnt_d       = '0;
               turn_d      = PLAYER_1;
               game_over_d = 1'b0;
               winner_d    = WIN_NONE;
`ifdef MOVE_UNDO_EN
               last_pos_d  = 4'd0;
               last_turn_d = 2'b00;
               last_vld_d  = 1'b0;
               undo_d      = 1'b0;
`endif
            end
         end
         default: state_d = S_POS;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= S_POS;
         pos_q        <= 4'd0;
         cnt_q        <= '0;
         turn_q       <= PLAYER_1;
         game_over_q  <= 1'b0;
         winner_q     <= WIN_NONE;
         wr_en_q      <= 1'b0;
         wr_pos_q     <= 4'd0;
         wr_sym_q     <= SYM_EMPTY;
         draw_start_q <= 1'b0;
         err_q        <= 1'b0;
`ifdef MOVE_UNDO_EN
         last_pos_q   <= 4'd0;
         last_turn_q  <= 2'b00;
         last_vld_q   <= 1'b0;
         undo_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         cnt_q        <= cnt_d;
         turn_q       <= turn_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
         wr_en_q      <= wr_en_d;
         wr_pos_q     <= wr_pos_d;
         wr_sym_q     <= wr_sym_d;
         draw_start_q <= draw_start_d;
         err_q        <= err_d;
`ifdef MOVE_UNDO_EN
         last_pos_q   <= last_pos_d;
         last_turn_q  <= last_turn_d;
         last_vld_q   <= last_vld_d;
         undo_q       <= undo_d;
`endif
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_pos     = wr_pos_q;
   assign wr_sym     = wr_sym_q;
   assign draw_start = draw_start_q;
   assign turn       = turn_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign err        = err_q;

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter DRAW_TIMEOUT, default 1024: maximum cycles spent waiting for draw_done.
REQ-002 SHALL have port clock, input, 1 bit: system clock; all state changes on the rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking a new keyboard character.
REQ-005 SHALL have port key_ascii, input, 7 bits: ASCII code, valid only while key_valid is high.
REQ-006 SHALL have port cell_state, input, 18 bits: board contents, cell n at bits [2n-1:2n-2], n = 1..9.
REQ-007 SHALL have port check, input, 1 bit: board end-condition flag, combinational from the board.
REQ-008 SHALL have port result, input, 2 bits: end result, 11 = tie, otherwise loss by the mover.
REQ-009 SHALL have port draw_done, input, 1 bit: one-cycle strobe from the renderer.
REQ-010 SHALL have port wr_en, output, 1 bit: board cell write strobe.
REQ-011 SHALL have port wr_pos, output, 4 bits: cell index to write, 1..9.
REQ-012 SHALL have port wr_sym, output, 2 bits: symbol to write.
REQ-013 SHALL have port draw_start, output, 1 bit: one-cycle render request.
REQ-014 SHALL have port turn, output, 2 bits: player to move, 01 = P1, 10 = P2.
REQ-015 SHALL have port game_over, output, 1 bit: high while the game has ended.
REQ-016 SHALL have port winner, output, 2 bits: 01 = P1, 10 = P2, 11 = tie, 00 = none.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse flagging a rejected key or a draw timeout.

Function
REQ-018 Symbol encoding SHALL be: empty 00, X 01, O 10.
REQ-019 States SHALL be S_POS, S_SYM, S_COMMIT, S_DRAW, S_DRAW_WAIT, S_CHECK and S_OVER.
REQ-020 S_POS: an ASCII digit '1'..'9' whose cell is 00 SHALL latch the position and go to S_SYM.
- Occupied cell: err pulse, stay in S_POS.
- Any other key: err pulse, stay in S_POS.
REQ-021 S_SYM: 'x'/'X' SHALL latch symbol 01 and 'o'/'O' SHALL latch 10, then go to S_COMMIT.
- Empty digit '1'..'9': replaces the latched position, no err.
- Any other key, including an occupied digit: err pulse, stay in S_SYM.
REQ-022 S_COMMIT SHALL last one cycle, asserting wr_en with the latched wr_pos and wr_sym, then go to S_DRAW.
REQ-023 S_DRAW SHALL assert draw_start for one cycle, then go to S_DRAW_WAIT and clear the timeout counter.
REQ-024 S_DRAW_WAIT SHALL go to S_CHECK on draw_done.
- If DRAW_TIMEOUT cycles elapse first: err pulse, go to S_CHECK.
REQ-025 S_CHECK SHALL sample check for one cycle; by then the board holds the committed move, at least 2 cycles after wr_en.
- check = 0: toggle turn, go to S_POS.
- check = 1 and result = 11: winner = 11, go to S_OVER.
- check = 1, otherwise: winner = the non-moving player, go to S_OVER.
REQ-026 S_OVER SHALL hold game_over = 1 and winner stable.
- Key 'r'/'R': return to the reset state without writing the board.
- All other keys: ignored, no err.
REQ-027 key_valid in S_COMMIT, S_DRAW, S_DRAW_WAIT or S_CHECK SHALL be ignored with no err and no buffering, including when it coincides with draw_done.
REQ-028 wr_pos and wr_sym SHALL read 0 whenever wr_en is low.
REQ-029 Commit-to-next-S_POS latency SHALL be 4 cycles when draw_done arrives in the first S_DRAW_WAIT cycle.

Reset
REQ-030 On resetn = 0 at a clock edge, the state SHALL be S_POS, turn = 01, and every other output plus all latches and counters SHALL be 0.
REQ-031 Reset SHALL take effect in any state, including mid-draw; no partial write SHALL be emitted afterwards.

Configuration
REQ-032 With macro MOVE_UNDO_EN defined, the key 'u'/'U' in S_POS SHALL undo the most recent committed move.
- Condition: at least one move has been committed since reset or the last undo.
- Action: one-cycle wr_en with that move's position and wr_sym = 00, then S_DRAW, then turn reverts with no toggle.
- Only one level of undo is held; a second 'u' gives an err pulse.
REQ-033 Without MOVE_UNDO_EN, 'u' SHALL be treated as an invalid key, and no last-move register SHALL be synthesized.

Structure
REQ-034 A shared package ttt_pkg SHALL hold the symbol codes, player codes, winner codes, the state enum and the ASCII constants.
REQ-035 The key decoding SHALL be one sub-module, key_classify: combinational from key_ascii to is_digit, digit value, is_x, is_o, is_r, is_u.

Verification
REQ-036 Reset; keys '5', 'x' -> wr_en pulse with pos 5, sym 01; draw_start one cycle later; after draw_done with check = 0, turn = 10.
REQ-037 With cell 5 = 01, key '5' in S_POS -> err pulse, no wr_en, state remains S_POS.
REQ-038 Keys '3', '7', 'o' -> single wr_en with pos 7, sym 10; '3' is overridden without err.
REQ-039 draw_done withheld -> err pulse exactly DRAW_TIMEOUT cycles after entering S_DRAW_WAIT, then S_CHECK.
REQ-040 P2 commit with check = 1, result = 01 -> game_over = 1, winner = 01; key 'r' -> turn = 01, game_over = 0.
REQ-041 With MOVE_UNDO_EN: move '2', 'x', then 'u' -> wr_en with pos 2, sym 00; turn back to 01; a second 'u' -> err.
